// File: rtl/ram_fifo_pkg.sv
// Shared defaults for the RAM-backed FIFO controller.
package ram_fifo_pkg;
   localparam int RAM_FIFO_DATA_W = 8;
   localparam int RAM_FIFO_ADDR_W = 6;
   localparam int RAM_FIFO_DEPTH  = 1 << RAM_FIFO_ADDR_W;
   localparam int RAM_FIFO_AF_LEVEL = 56;
endpackage

// File: rtl/ram_fifo_ptr.sv
// Wrapping ADDR_W-bit FIFO pointer with increment and synchronous clear.
module ram_fifo_ptr #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_inc,
   input  logic              i_clr,
   output logic [ADDR_W-1:0] o_ptr
);
   logic [ADDR_W-1:0] r_ptr;

   // Wrap from DEPTH-1 to 0 comes from the natural ADDR_W-bit overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_ptr <= '0;
      else if (i_clr)
         r_ptr <= '0;
      else if (i_inc)
         r_ptr <= r_ptr + ADDR_W'(1);
   end

   assign o_ptr = r_ptr;
endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM (port A write, port B read).
// Define RAM_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module ram_fifo_ctrl
   import ram_fifo_pkg::*;
#(
   parameter int DATA_W   = RAM_FIFO_DATA_W,
   parameter int ADDR_W   = RAM_FIFO_ADDR_W,
   parameter int AF_LEVEL = RAM_FIFO_AF_LEVEL
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow,
   output logic [ADDR_W-1:0] ram_addr_a,
   output logic [DATA_W-1:0] ram_data_a,
   output logic              ram_we_a,
   output logic [ADDR_W-1:0] ram_addr_b,
   output logic              ram_we_b,
   input  logic [DATA_W-1:0] ram_q_b
);
   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(1) << ADDR_W;
   localparam logic [ADDR_W:0] LP_AF    = (ADDR_W+1)'(AF_LEVEL);

   logic [ADDR_W:0]   r_count;
   logic              r_rd_valid;
   logic              w_push;
   logic              w_pop;
   logic [ADDR_W-1:0] w_wr_ptr;
   logic [ADDR_W-1:0] w_rd_ptr;

   // Flags come from the registered count only, so a same-cycle pop never frees room for a push.
   assign full        = (r_count == LP_DEPTH);
   assign empty       = (r_count == '0);
   assign almost_full = (r_count >= LP_AF);
   assign count       = r_count;

   assign w_push = wr_en & ~full  & ~flush;
   assign w_pop  = rd_en & ~empty & ~flush;

   ram_fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_push),
      .i_clr (flush),
      .o_ptr (w_wr_ptr)
   );

   ram_fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_pop),
      .i_clr (flush),
      .o_ptr (w_rd_ptr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count    <= '0;
         r_rd_valid <= 1'b0;
      end else if (flush) begin
         r_count    <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_pop;
         if (w_push && !w_pop)
            r_count <= r_count + (ADDR_W+1)'(1);
         else if (w_pop && !w_push)
            r_count <= r_count - (ADDR_W+1)'(1);
      end
   end

   // RAM q_b is registered on the pop edge, so it lines up with r_rd_valid.
   assign rd_data    = ram_q_b;
   assign rd_valid   = r_rd_valid;

   assign ram_addr_a = w_wr_ptr;
   assign ram_data_a = wr_data;
   assign ram_we_a   = w_push;
   assign ram_addr_b = w_rd_ptr;
   assign ram_we_b   = 1'b0;

`ifdef RAM_FIFO_ERR_EN
   logic r_overflow;
   logic r_underflow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (flush) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (wr_en && full)
            r_overflow <= 1'b1;
         if (rd_en && empty)
            r_underflow <= 1'b1;
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural dual-port RAM beside it.
module tb_ram_fifo_ctrl;
   localparam int DW = 8;
   localparam int AW = 6;
`ifdef RAM_FIFO_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] rd_data;
   logic          rd_valid, full, empty, almost_full, overflow, underflow;
   logic [AW:0]   count;
   logic [AW-1:0] ram_addr_a, ram_addr_b;
   logic [DW-1:0] ram_data_a, ram_q_b;
   logic          ram_we_a, ram_we_b;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(56)) dut (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
      .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
      .empty(empty), .almost_full(almost_full), .count(count),
      .overflow(overflow), .underflow(underflow), .ram_addr_a(ram_addr_a),
      .ram_data_a(ram_data_a), .ram_we_a(ram_we_a), .ram_addr_b(ram_addr_b),
      .ram_we_b(ram_we_b), .ram_q_b(ram_q_b)
   );

   always @(posedge clk) begin
      if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
      if (ram_we_b) mem[ram_addr_b] <= 8'hEE;
      ram_q_b <= mem[ram_addr_b];
   end

   typedef struct {
      bit            fl, we, re;
      logic [DW-1:0] wd;
      int            cnt;
      bit            emp, vld, chkdat;
      logic [DW-1:0] dat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input bit fl, input bit we, input logic [DW-1:0] wd, input bit re);
      @(negedge clk);
      flush = fl; wr_en = we; wr_data = wd; rd_en = re;
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[9];

   initial begin
      for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
      ram_q_b = '0;

      // start-of-test table: fl we re wd cnt emp vld chkdat dat
      vecs[0] = '{0,1,0,8'h11,1,0,0,0,8'h00};
      vecs[1] = '{0,1,0,8'h22,2,0,0,0,8'h00};
      vecs[2] = '{0,0,1,8'h00,1,0,1,1,8'h11};
      vecs[3] = '{0,1,1,8'h33,1,0,1,1,8'h22};
      vecs[4] = '{0,0,1,8'h00,0,1,1,1,8'h33};
      vecs[5] = '{0,0,1,8'h00,0,1,0,0,8'h00};
      vecs[6] = '{0,1,1,8'h44,1,0,0,0,8'h00};
      vecs[7] = '{0,0,0,8'h00,1,0,0,0,8'h00};
      vecs[8] = '{1,1,0,8'h55,0,1,0,0,8'h00};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_empty", 32'(empty), 1);
      chk("reset_full", 32'(full), 0);
      chk("reset_af", 32'(almost_full), 0);
      chk("reset_count", 32'(count), 0);
      chk("reset_valid", 32'(rd_valid), 0);
      chk("reset_ovf", 32'(overflow), 0);
      chk("reset_unf", 32'(underflow), 0);
      chk("we_b_const", 32'(ram_we_b), 0);

      for (int v = 0; v < 9; v++) begin
         step(vecs[v].fl, vecs[v].we, vecs[v].wd, vecs[v].re);
         chk($sformatf("vec%0d_count", v), 32'(count), 32'(vecs[v].cnt));
         chk($sformatf("vec%0d_empty", v), 32'(empty), 32'(vecs[v].emp));
         chk($sformatf("vec%0d_valid", v), 32'(rd_valid), 32'(vecs[v].vld));
         if (vecs[v].chkdat)
            chk($sformatf("vec%0d_data", v), 32'(rd_data), 32'(vecs[v].dat));
         if (v == 5) chk("unf_after_empty_pop", 32'(underflow), 32'(ERR));
         if (v == 7) chk("unf_sticky", 32'(underflow), 32'(ERR));
      end
      chk("unf_cleared_by_flush", 32'(underflow), 0);

      // async reset mid-cycle while a word is valid
      step(0,1,8'h66,0);
      step(0,0,8'h00,1);
      chk("pre_rst_valid", 32'(rd_valid), 1);
      step(0,1,8'h77,0);
      step(0,0,8'h00,1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_empty", 32'(empty), 1);
      chk("async_rst_count", 32'(count), 0);
      chk("async_rst_valid", 32'(rd_valid), 0);
      @(negedge clk);
      rd_en = 1'b0; wr_en = 1'b0; rst = 1'b0;

      // fill 0x00..0x3F
      for (int i = 0; i < 64; i++) begin
         step(0,1,8'(i),0);
         chk($sformatf("fill%0d_af", i), 32'(almost_full), 32'(i + 1 >= 56));
         chk($sformatf("fill%0d_full", i), 32'(full), 32'(i + 1 == 64));
      end
      chk("fill_count", 32'(count), 64);
      step(0,1,8'hFF,0);
      chk("push_full_count", 32'(count), 64);
      chk("ovf_set", 32'(overflow), 32'(ERR));
      // push+pop at full: pop wins, push dropped
      step(0,1,8'hFE,1);
      chk("pp_full_count", 32'(count), 63);
      chk("pp_full_valid", 32'(rd_valid), 1);
      chk("pp_full_data", 32'(rd_data), 0);
      for (int i = 1; i < 64; i++) begin
         step(0,0,8'h00,1);
         chk($sformatf("drain%0d_valid", i), 32'(rd_valid), 1);
         chk($sformatf("drain%0d_data", i), 32'(rd_data), 32'(i));
      end
      chk("drain_empty", 32'(empty), 1);
      step(0,0,8'h00,1);
      chk("drain_extra_valid", 32'(rd_valid), 0);
      chk("ovf_sticky", 32'(overflow), 32'(ERR));
      chk("unf_set2", 32'(underflow), 32'(ERR));
      step(1,0,8'h00,0);
      chk("ovf_flush", 32'(overflow), 0);
      chk("unf_flush", 32'(underflow), 0);

      // wrap-around: two rounds of 40 cross the 63->0 pointer wrap
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 40; i++) step(0,1,8'(8'hA0 + i),0);
         chk($sformatf("wrap%0d_count", r), 32'(count), 40);
         for (int i = 0; i < 40; i++) begin
            step(0,0,8'h00,1);
            chk($sformatf("wrap%0d_d%0d", r, i), 32'(rd_data), 32'(8'hA0 + i));
         end
         chk($sformatf("wrap%0d_empty", r), 32'(empty), 1);
      end
      chk("wrap_ptr_a", 32'(ram_addr_a), 16);
      chk("wrap_ptr_b", 32'(ram_addr_b), 16);

      // simultaneous at count 5
      for (int i = 0; i < 5; i++) step(0,1,8'(8'h50 + i),0);
      step(0,1,8'h5F,1);
      chk("pp5_count", 32'(count), 5);
      chk("pp5_data", 32'(rd_data), 32'h50);

      // flush at count 10 with wr_en high
      for (int i = 0; i < 5; i++) step(0,1,8'(i),0);
      chk("pre_flush_count", 32'(count), 10);
      @(negedge clk);
      flush = 1'b1; wr_en = 1'b1; wr_data = 8'hCC; rd_en = 1'b1;
      #1;
      chk("flush_we_a", 32'(ram_we_a), 0);
      @(posedge clk);
      #1;
      chk("flush_count", 32'(count), 0);
      chk("flush_empty", 32'(empty), 1);
      chk("flush_valid", 32'(rd_valid), 0);
      step(0,0,8'h00,0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Write/read controller that turns the dual-port RAM into a synchronous FIFO. It sits directly upstream of `dual_port_ram`, driving port A as the write port and port B as the read-only port. It consumes the RAM's registered `q_b` output and presents it on a pop-style read interface. It owns the pointers, occupancy, status flags and flush; the RAM instance stays outside this block.

## Interface
Parameters:
- `DATA_W`, 8: word width; must match the RAM data width.
- `ADDR_W`, 6: RAM address width; depth `DEPTH = 2**ADDR_W` (64).
- `AF_LEVEL`, 56: `almost_full` asserts when count ≥ `AF_LEVEL`; legal range 1..DEPTH.

Ports:
- `clk`  in  1  single clock for the block and the RAM.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous clear of pointers and count.
- `wr_en`  in  1  push request.
- `wr_data`  in  DATA_W  push data.
- `rd_en`  in  1  pop request.
- `rd_data`  out  DATA_W  popped word; valid while `rd_valid` = 1.
- `rd_valid`  out  1  `rd_data` is valid this cycle.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count ≥ AF_LEVEL.
- `count`  out  ADDR_W+1  occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: push attempted while full.
- `underflow`  out  1  sticky: pop attempted while empty.
- `ram_addr_a`  out  ADDR_W  drive RAM `addr_a`; equals `wr_ptr`.
- `ram_data_a`  out  DATA_W  drive RAM `data_a`; equals `wr_data`.
- `ram_we_a`  out  1  drive RAM `we_a`.
- `ram_addr_b`  out  ADDR_W  drive RAM `addr_b`; equals `rd_ptr`.
- `ram_we_b`  out  1  drive RAM `we_b`; constant 0.
- `ram_q_b`  in  DATA_W  RAM `q_b`.

## Operation
- Accepted push: `push = wr_en & ~full & ~flush`. `ram_we_a = push`, combinational.
- Accepted pop: `pop = rd_en & ~empty & ~flush`.
- Flags are computed from the registered `count` only. A push into a full FIFO is dropped, even if a pop occurs in the same cycle. A pop from an empty FIFO is ignored, even if a push occurs in the same cycle.
- On each edge:
  - `wr_ptr += push`.
  - `rd_ptr += pop`.
  - `count += push - pop`.
  - Pointers wrap modulo DEPTH, with natural ADDR_W overflow from 63 to 0.
  - Simultaneous push and pop leaves `count` unchanged.
- `flush`: on the next edge `wr_ptr`, `rd_ptr` and `count` go to 0, and `rd_valid` goes to 0. RAM contents are untouched. `flush` overrides `wr_en` and `rd_en`.
- Read path:
  - `ram_addr_b = rd_ptr`. The RAM registers `memory[rd_ptr]` into `q_b` on the edge where `pop` = 1.
  - `rd_valid` is a register loaded with `pop`.
  - `rd_data = ram_q_b`, passed through combinationally.
- Same-address hazard: the write and read addresses coincide only when empty or full. Pop is blocked when empty and push is blocked when full, so no read-during-write to the same address can occur.

## Timing
- Reset values: `wr_ptr` = `rd_ptr` = `count` = 0, `rd_valid` = 0, `overflow` = `underflow` = 0. This gives `empty` = 1, `full` = 0, `almost_full` = 0.
- Write latency: data pushed at edge N is readable by a pop at edge N+1. On the cycle after the push, `empty` is 0.
- Read latency: pop at edge N gives `rd_valid` = 1 with the data in cycle N..N+1. The data holds for exactly one cycle, so the consumer must accept it unconditionally.
- Back-to-back pops produce one word per cycle with no bubbles.
- Reset asserted mid-operation clears all state asynchronously. Stale `ram_q_b` is never flagged valid.

## Configuration
- `RAM_FIFO_ERR_EN` defined:
  - `overflow` sets on `wr_en & full`.
  - `underflow` sets on `rd_en & empty`.
  - Both are sticky until `rst` or `flush`.
- Undefined: `overflow` and `underflow` are tied to 0 and no flag registers are built.

## Structure
- Package `ram_fifo_pkg`: default `DATA_W`/`ADDR_W` constants and the derived `DEPTH`.
- One sub-module, `ram_fifo_ptr`: a wrapping ADDR_W-bit pointer with `inc` and `clr` inputs, instantiated twice (write and read pointers).
- Top-level connection: the `dual_port_ram` instance is wired beside this block by the parent.

## Test plan
- **Reset:** assert `rst` asynchronously mid-clock → `empty` = 1, `count` = 0, `rd_valid` = 0 immediately.
- **Fill and drain:** push 0x00..0x3F, then pop 64 times.
  - Push phase: `full` = 1 after the 64th push, `almost_full` = 1 from count 56.
  - Pop phase: `rd_data` sequence is 0x00..0x3F, one per cycle; `empty` = 1 at the end.
- **Wrap-around:** push 40, pop 40, push 40, pop 40 with values 0xA0+i → data is in order across the 63→0 pointer wrap.
- **Simultaneous push/pop:**
  - At count 5: `count` stays 5.
  - At count 0: push accepted, pop ignored → `count` = 1, `rd_valid` = 0.
  - At count 64: pop accepted, push dropped → `count` = 63.
- **Flush:** at count 10, `flush` with `wr_en` = 1 → `count` = 0, `empty` = 1, nothing written (`ram_we_a` = 0).
- **Error flags (with `RAM_FIFO_ERR_EN`):**
  - `wr_en` while full → `overflow` = 1.
  - `rd_en` while empty → `underflow` = 1.
  - Both stay set until `flush`; both stay 0 in a build without the macro.
